// File: rtl/alu_control_single_pkg.sv
// Shared encodings for the single-cycle MIPS ALU control path:
// aluop classes, R-type funct values and ALU operation codes.
package single_defs;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_RSVD   = 2'b11
    } aluop_t;

    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;
    localparam logic [3:0] ALU_SRL = 4'b1110;
    localparam logic [3:0] ALU_SLL = 4'b1111;

endpackage

// File: rtl/alu_control_single_decode.sv
// Combinational ALU control decode. Define ALU_CTRL_EXT_FUNCT_EN to also
// accept the NOR/SRL/XOR R-type functions.
module alu_control_decode
    import single_defs::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] functioncode_i,
    output logic [3:0] aluoperation_o,
    output logic       illegal_o
);

    // funct is only inspected inside the R-type arm so it cannot leak otherwise
    always_comb begin
        aluoperation_o = ALU_ADD;
        illegal_o      = 1'b0;
        case (aluop_t'(aluop_i))
            ALUOP_MEM:    aluoperation_o = ALU_ADD;
            ALUOP_BRANCH: aluoperation_o = ALU_SUB;
            ALUOP_RTYPE: begin
                case (functioncode_i)
                    FUNCT_SLL: aluoperation_o = ALU_SLL;
                    FUNCT_ADD: aluoperation_o = ALU_ADD;
                    FUNCT_SUB: aluoperation_o = ALU_SUB;
                    FUNCT_AND: aluoperation_o = ALU_AND;
                    FUNCT_OR:  aluoperation_o = ALU_OR;
                    FUNCT_SLT: aluoperation_o = ALU_SLT;
`ifdef ALU_CTRL_EXT_FUNCT_EN
                    FUNCT_NOR: aluoperation_o = ALU_NOR;
                    FUNCT_SRL: aluoperation_o = ALU_SRL;
                    FUNCT_XOR: aluoperation_o = ALU_XOR;
`endif
                    default: begin
                        aluoperation_o = ALU_ADD;
                        illegal_o      = 1'b1;
                    end
                endcase
            end
            default: begin
                aluoperation_o = ALU_ADD;
                illegal_o      = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_control_single.sv
// Registered ALU control decoder: one-cycle latency, captures on in_valid.
// Optional extended R-type functions via ALU_CTRL_EXT_FUNCT_EN.
module alu_control_single
    import single_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] aluop,
    input  logic [5:0] functioncode,
    output logic [3:0] aluoperation,
    output logic       illegal,
    output logic       out_valid
);

    logic [3:0] dec_op;
    logic       dec_illegal;
    logic [3:0] aluoperation_q, aluoperation_d;
    logic       illegal_q, illegal_d;
    logic       out_valid_q;

    alu_control_decode u_decode (
        .aluop_i        (aluop),
        .functioncode_i (functioncode),
        .aluoperation_o (dec_op),
        .illegal_o      (dec_illegal)
    );

    // Decoded values are only taken on a valid strobe; otherwise hold
    assign aluoperation_d = in_valid ? dec_op      : aluoperation_q;
    assign illegal_d      = in_valid ? dec_illegal : illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluoperation_q <= ALU_ADD;
            illegal_q      <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            aluoperation_q <= aluoperation_d;
            illegal_q      <= illegal_d;
            out_valid_q    <= in_valid;
        end
    end

    assign aluoperation = aluoperation_q;
    assign illegal      = illegal_q;
    assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_alu_control_single.sv
// Scoreboard bench for alu_control_single: directed plan items plus random
// traffic, checked against a table-driven reference of the decode rules.
module tb_alu_control_single;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] aluop;
    logic [5:0] functioncode;
    logic [3:0] aluoperation;
    logic       illegal;
    logic       out_valid;

    alu_control_single dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .aluop        (aluop),
        .functioncode (functioncode),
        .aluoperation (aluoperation),
        .illegal      (illegal),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] op;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    int   checks = 0;
    int   errors = 0;

    // R-type function table; the last three entries are the extended set
    localparam logic [5:0] FN_TAB [9] = '{6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A,
                                          6'h27, 6'h02, 6'h26};
    localparam logic [3:0] OP_TAB [9] = '{4'hF, 4'h2, 4'h6, 4'h0, 4'h1, 4'h7,
                                          4'hC, 4'hE, 4'hD};
`ifdef ALU_CTRL_EXT_FUNCT_EN
    localparam int N_LEGAL = 9;
`else
    localparam int N_LEGAL = 6;
`endif

    function automatic exp_t ref_decode(input logic [1:0] op, input logic [5:0] f);
        exp_t r;
        r.op  = 4'h2;
        r.ill = 1'b0;
        if (op == 2'd1) r.op = 4'h6;
        else if (op == 2'd3) r.ill = 1'b1;
        else if (op == 2'd2) begin
            r.ill = 1'b1;
            for (int i = 0; i < N_LEGAL; i++) begin
                if (FN_TAB[i] == f) begin
                    r.op  = OP_TAB[i];
                    r.ill = 1'b0;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: out_valid 1 with empty scoreboard at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("aluoperation", aluoperation, e.op);
                        chk("illegal", {3'b0, illegal}, {3'b0, e.ill});
                        held = e;
                    end
                end else begin
                    chk("hold_aluoperation", aluoperation, held.op);
                    chk("hold_illegal", {3'b0, illegal}, {3'b0, held.ill});
                end
            end
        end
    endtask

    task automatic issue(input logic v, input logic [1:0] op, input logic [5:0] f);
        @(posedge clk);
        #1;
        in_valid     = v;
        aluop        = op;
        functioncode = f;
        if (v) sb.push_back(ref_decode(op, f));
    endtask

    task automatic check_reset_values();
        chk("rst_aluoperation", aluoperation, 4'h2);
        chk("rst_illegal", {3'b0, illegal}, 4'h0);
        chk("rst_out_valid", {3'b0, out_valid}, 4'h0);
    endtask

    task automatic reset_mid_cycle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        sb.delete();
        held     = '{op: 4'h2, ill: 1'b0};
        in_valid = 1'b0;
        @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    function automatic logic [5:0] rand_funct();
        if ($urandom_range(0, 9) < 6) return FN_TAB[$urandom_range(0, 8)];
        return 6'($urandom);
    endfunction

    initial begin
        rst_n        = 1'b1;
        in_valid     = 1'b0;
        aluop        = 2'b00;
        functioncode = 6'h00;
        held         = '{op: 4'h2, ill: 1'b0};
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        #9;
        rst_n = 1'b1;
        fork
            monitor();
        join_none

        // Directed plan items
        issue(1'b1, 2'b00, 6'($urandom));
        issue(1'b1, 2'b01, 6'($urandom));
        issue(1'b1, 2'b10, 6'h20);
        issue(1'b1, 2'b10, 6'h22);
        issue(1'b1, 2'b10, 6'h24);
        issue(1'b1, 2'b10, 6'h25);
        issue(1'b1, 2'b10, 6'h2A);
        issue(1'b1, 2'b10, 6'h00);
        issue(1'b1, 2'b10, 6'h3F);
        issue(1'b1, 2'b11, 6'($urandom));
        issue(1'b1, 2'b01, 6'h00);
        issue(1'b0, 2'b10, 6'h24);
        issue(1'b0, 2'b10, 6'h24);
        issue(1'b1, 2'b10, 6'h27);
        issue(1'b1, 2'b10, 6'h02);
        issue(1'b1, 2'b10, 6'h26);
        issue(1'b0, 2'b00, 6'h00);

        reset_mid_cycle();

        for (int i = 0; i < 400; i++) begin
            issue(($urandom_range(0, 3) != 0), 2'($urandom), rand_funct());
            if (i == 200) reset_mid_cycle();
        end

        for (int i = 0; i < 4; i++) issue(1'b0, 2'($urandom), 6'($urandom));
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs never presented, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
